mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL provide parameter STARVE_MAX, default 4, meaning the number of consecutive data grants allowed while an instruction request waits.
REQ-002 SHALL provide port CLK  in  1  system clock; all state updates on rising edge.
REQ-003 SHALL provide port RST  in  1  reset, asynchronous, active-high.
REQ-004 SHALL provide port iREN  in  1  instruction read request.
REQ-005 SHALL provide port iaddr  in  32  instruction address.
REQ-006 SHALL provide port iwait  out  1  instruction stall; low only in the completion cycle.
REQ-007 SHALL provide port iload  out  32  instruction read data.
REQ-008 SHALL provide port dREN  in  1  data read request.
REQ-009 SHALL provide port dWEN  in  1  data write request.
REQ-010 SHALL provide port daddr  in  32  data address.
REQ-011 SHALL provide port dstore  in  32  data write value.
REQ-012 SHALL provide port dwait  out  1  data stall; low only in the completion cycle.
REQ-013 SHALL provide port dload  out  32  data read data.
REQ-014 SHALL provide port ramREN / ramWEN  out  1 each  RAM read/write strobe.
REQ-015 SHALL provide port ramaddr, ramstore  out  32 each  RAM address and write data.
REQ-016 SHALL provide port ramload  in  32  RAM read data.
REQ-017 SHALL provide port ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Function
REQ-018 SHALL implement a registered FSM with states IDLE, IGNT, DGNT.
REQ-019 IDLE: dREN|dWEN -> DGNT; else iREN -> IGNT; else stay. Exception: starve_cnt==STARVE_MAX and iREN -> IGNT.
REQ-020 In IDLE, ramREN=ramWEN=0, ramaddr=0, ramstore=0, iwait=dwait=1.
REQ-021 IGNT SHALL drive ramREN=1, ramWEN=0, ramaddr=iaddr, ramstore=0; dwait=1.
REQ-022 DGNT SHALL drive ramaddr=daddr and ramstore=dstore; if dWEN, ramWEN=1 and ramREN=0; else ramREN=1 and ramWEN=0. With dREN&dWEN both high, write wins.
REQ-023 In a granted state with ramstate==ACCESS, the granted requester's wait SHALL be 0 combinationally in that cycle, and the next state SHALL be IDLE.
REQ-024 iload SHALL equal ramload in IGNT, else 0; dload SHALL equal ramload in DGNT, else 0.
REQ-025 In a granted state with ramstate FREE or BUSY, the FSM SHALL hold the state and keep wait high.
REQ-026 In a granted state with ramstate==ERROR, the FSM SHALL return to IDLE with wait still high, so the still-asserted request is retried.
REQ-027 If the granted requester deasserts all its enables before ACCESS, the FSM SHALL return to IDLE next cycle; RAM strobes follow the inputs combinationally (drop in that cycle).
REQ-028 Completion SHALL always be followed by exactly one IDLE cycle, so a request held through its completion cycle is not reissued.
REQ-029 starve_cnt rules (3-bit saturating counter):
- Increments on each DGNT completion while iREN is high.
- Clears on IGNT completion or when iREN is low at a DGNT completion.
- Saturates at STARVE_MAX.
REQ-030 Minimum latency SHALL be 2 cycles from request to completion: one IDLE cycle, then the grant cycle with an immediate ACCESS.

Reset
REQ-031 RST high SHALL immediately force state=IDLE and starve_cnt=0.
REQ-032 Under reset, outputs SHALL be: iwait=dwait=1, ramREN=ramWEN=0, ramaddr=ramstore=0, iload=dload=0.
REQ-033 Reset asserted mid-grant SHALL abandon the transaction with no completion signalled; after release, arbitration restarts from IDLE.

Structure
REQ-034 The ramstate_t enum (FREE/BUSY/ACCESS/ERROR) and word_t (32-bit) SHALL live in the shared cpu_types_pkg.
REQ-035 The arbiter state enum and starve counter SHALL be local to the module; no sub-module is required.
REQ-036 The module SHALL be RTL-only, one always_ff for state/counter and one always_comb for next-state/outputs.

Verification
REQ-037 Only iREN=1, iaddr=0x40; ramstate ACCESS in the second cycle -> ramREN=1, ramaddr=0x40 in the grant cycle, iwait=0 and iload=ramload, then IDLE.
REQ-038 dWEN=1 and iREN=1 together, daddr=0x100, dstore=0xDEADBEEF -> DGNT first: ramWEN=1, ramstore=0xDEADBEEF; IGNT after the completion plus one IDLE cycle.
REQ-039 dREN and iREN held continuously, ACCESS on every grant cycle -> exactly 4 data grants, then 1 instruction grant, then the pattern repeats.
REQ-040 DGNT with ramstate BUSY for 3 cycles then ACCESS -> dwait stays 1 for those 3 cycles, dwait=0 on the ACCESS cycle, no grant switch.
REQ-041 IGNT with ramstate=ERROR -> IDLE next cycle with iwait=1, then IGNT reissued with the same iaddr.
REQ-042 RST pulsed mid-DGNT -> ramWEN=0 and dwait=1 in the same cycle, starve_cnt=0; after release, the held request is re-granted from IDLE.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM status encoding and the machine word.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage : cpu_types_pkg

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the instruction fetch and data ports.
// Data requests win in IDLE unless the instruction port has been starved
// for STARVE_MAX consecutive data grants. Every completion, error or
// abandon passes through one IDLE cycle before the next grant.
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);
    import cpu_types_pkg::*;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

    localparam logic [2:0] STARVE_LIMIT = 3'(STARVE_MAX);

    arb_state_t state, next_state;
    logic [2:0] starve_cnt, next_starve_cnt;
    ramstate_t  ram_status;

    assign ram_status = ramstate_t'(ramstate);

    // State register and starvation counter; reset abandons any grant.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state      <= next_state;
            starve_cnt <= next_starve_cnt;
        end
    end

    // Next-state selection and the combinational RAM / requester outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        next_state      = state;
        next_starve_cnt = starve_cnt;
        ramREN          = 1'b0;
        ramWEN          = 1'b0;
        ramaddr         = '0;
        ramstore        = '0;
        iwait           = 1'b1;
        dwait           = 1'b1;
        iload           = '0;
        dload           = '0;

        unique case (state)
            IDLE: begin
                if (starve_cnt == STARVE_LIMIT && iREN) begin
                    next_state = IGNT;
                end else if (dREN || dWEN) begin
                    next_state = DGNT;
                end else if (iREN) begin
                    next_state = IGNT;
                end
            end

            IGNT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iload   = ramload;
                if (!iREN) begin
                    // Fetch withdrawn before the RAM answered.
                    next_state = IDLE;
                end else if (ram_status == ACCESS) begin
                    iwait           = 1'b0;
                    next_state      = IDLE;
                    next_starve_cnt = '0;
                end else if (ram_status == ERROR) begin
                    // Drop back so the still-held request is reissued.
                    next_state = IDLE;
                end
            end

            DGNT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN && !dWEN;
                dload    = ramload;
                if (!(dREN || dWEN)) begin
                    next_state = IDLE;
                end else if (ram_status == ACCESS) begin
                    dwait      = 1'b0;
                    next_state = IDLE;
                    if (!iREN) begin
                        next_starve_cnt = '0;
                    end else if (starve_cnt < STARVE_LIMIT) begin
                        next_starve_cnt = starve_cnt + 3'd1;
                    end
                end else if (ram_status == ERROR) begin
                    next_state = IDLE;
                end
            end

            default: next_state = IDLE;
        endcase
    end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change 1 ns after the rising
// edge, outputs are sampled 1 ns later, well clear of the next edge.
module tb_mem_arbiter;

    logic        CLK;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        iREN     = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        ramstate = RS_FREE;
    endtask

    task automatic test_reset();
        RST      = 1'b1;
        iREN     = 1'b1;
        iaddr    = 32'h1111_0000;
        dREN     = 1'b1;
        dWEN     = 1'b1;
        daddr    = 32'h2222_0000;
        dstore   = 32'h3333_0000;
        ramload  = 32'hCAFE_F00D;
        ramstate = RS_ACCESS;
        repeat (2) tick();
        n_checks++;
        if ({ramREN, ramWEN, iwait, dwait} !== 4'b0011) begin
            n_errors++;
            $display("FAIL reset_strobes: got %b expected 0011", {ramREN, ramWEN, iwait, dwait});
        end
        n_checks++;
        if ({ramaddr, ramstore, iload, dload} !== 128'd0) begin
            n_errors++;
            $display("FAIL reset_buses: got addr=%h store=%h iload=%h dload=%h expected all zero",
                     ramaddr, ramstore, iload, dload);
        end
        idle_inputs();
        RST = 1'b0;
        tick();
    endtask

    task automatic test_instr_fetch();
        iREN = 1'b1; iaddr = 32'h40; ramstate = RS_FREE;
        #1;
        n_checks++;
        if ({ramREN, iwait} !== 2'b01) begin
            n_errors++;
            $display("FAIL fetch_idle: got ramREN,iwait=%b expected 01", {ramREN, iwait});
        end
        tick();
        ramstate = RS_ACCESS; ramload = 32'h1234_5678;
        #1;
        n_checks++;
        if ({ramREN, ramWEN, iwait, dwait} !== 4'b1001 || ramaddr !== 32'h40 || iload !== 32'h1234_5678) begin
            n_errors++;
            $display("FAIL fetch_grant: got strobes=%b addr=%h iload=%h expected 1001 40 12345678",
                     {ramREN, ramWEN, iwait, dwait}, ramaddr, iload);
        end
        tick();
        #1;
        n_checks++;
        if ({ramREN, iwait} !== 2'b01 || iload !== 32'd0) begin
            n_errors++;
            $display("FAIL fetch_after: got ramREN,iwait=%b iload=%h expected 01 0", {ramREN, iwait}, iload);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_write_priority();
        dWEN = 1'b1; iREN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
        iaddr = 32'h80; ramstate = RS_FREE;
        #1;
        n_checks++;
        if ({ramREN, ramWEN} !== 2'b00) begin
            n_errors++;
            $display("FAIL prio_idle: got ramREN,ramWEN=%b expected 00", {ramREN, ramWEN});
        end
        tick();
        ramstate = RS_ACCESS;
        #1;
        n_checks++;
        if ({ramREN, ramWEN, iwait, dwait} !== 4'b0110 || ramaddr !== 32'h100 || ramstore !== 32'hDEAD_BEEF) begin
            n_errors++;
            $display("FAIL prio_dgnt: got strobes=%b addr=%h store=%h expected 0110 100 deadbeef",
                     {ramREN, ramWEN, iwait, dwait}, ramaddr, ramstore);
        end
        dWEN = 1'b0;
        tick();
        ramstate = RS_FREE;
        #1;
        n_checks++;
        if ({ramREN, ramWEN, iwait, dwait} !== 4'b0011) begin
            n_errors++;
            $display("FAIL prio_gap: got strobes=%b expected 0011", {ramREN, ramWEN, iwait, dwait});
        end
        tick();
        ramstate = RS_ACCESS;
        #1;
        n_checks++;
        if ({ramREN, ramWEN, iwait, dwait} !== 4'b1001 || ramaddr !== 32'h80) begin
            n_errors++;
            $display("FAIL prio_ignt: got strobes=%b addr=%h expected 1001 80",
                     {ramREN, ramWEN, iwait, dwait}, ramaddr);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_starvation();
        dREN = 1'b1; iREN = 1'b1; daddr = 32'h200; iaddr = 32'h300; ramstate = RS_ACCESS;
        for (int k = 0; k < 20; k++) begin
            logic [1:0]  exp_w;
            logic [31:0] exp_a;
            if (k % 2 == 0) begin
                exp_w = 2'b11; exp_a = 32'h0;
            end else if (((k - 1) / 2) % 5 == 4) begin
                exp_w = 2'b01; exp_a = 32'h300;
            end else begin
                exp_w = 2'b10; exp_a = 32'h200;
            end
            #1;
            n_checks++;
            if ({iwait, dwait} !== exp_w || ramaddr !== exp_a) begin
                n_errors++;
                $display("FAIL starve_cycle%0d: got iwait,dwait=%b addr=%h expected %b %h",
                         k, {iwait, dwait}, ramaddr, exp_w, exp_a);
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_busy_wait();
        dREN = 1'b1; daddr = 32'h44; ramstate = RS_BUSY;
        tick();
        iREN = 1'b1; iaddr = 32'h88; ramload = 32'h5555_AAAA;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if ({ramREN, iwait, dwait} !== 3'b111 || ramaddr !== 32'h44) begin
                n_errors++;
                $display("FAIL busy_cycle%0d: got ramREN,iwait,dwait=%b addr=%h expected 111 44",
                         k, {ramREN, iwait, dwait}, ramaddr);
            end
            tick();
        end
        ramstate = RS_ACCESS;
        #1;
        n_checks++;
        if ({iwait, dwait} !== 2'b10 || ramaddr !== 32'h44 || dload !== 32'h5555_AAAA) begin
            n_errors++;
            $display("FAIL busy_done: got iwait,dwait=%b addr=%h dload=%h expected 10 44 5555aaaa",
                     {iwait, dwait}, ramaddr, dload);
        end
        dREN = 1'b0;
        tick();
        tick();
        #1;
        n_checks++;
        if ({iwait, dwait} !== 2'b01 || ramaddr !== 32'h88) begin
            n_errors++;
            $display("FAIL busy_then_fetch: got iwait,dwait=%b addr=%h expected 01 88",
                     {iwait, dwait}, ramaddr);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_error_retry();
        iREN = 1'b1; iaddr = 32'hC0;
        tick();
        ramstate = RS_ERROR;
        #1;
        n_checks++;
        if ({ramREN, iwait} !== 2'b11 || ramaddr !== 32'hC0) begin
            n_errors++;
            $display("FAIL err_grant: got ramREN,iwait=%b addr=%h expected 11 c0", {ramREN, iwait}, ramaddr);
        end
        tick();
        ramstate = RS_FREE;
        #1;
        n_checks++;
        if ({ramREN, iwait} !== 2'b01) begin
            n_errors++;
            $display("FAIL err_idle: got ramREN,iwait=%b expected 01", {ramREN, iwait});
        end
        tick();
        ramstate = RS_ACCESS;
        #1;
        n_checks++;
        if ({ramREN, iwait} !== 2'b10 || ramaddr !== 32'hC0) begin
            n_errors++;
            $display("FAIL err_retry: got ramREN,iwait=%b addr=%h expected 10 c0", {ramREN, iwait}, ramaddr);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_abandon();
        dREN = 1'b1; daddr = 32'h10; ramstate = RS_BUSY;
        tick();
        dREN = 1'b0;
        #1;
        n_checks++;
        if ({ramREN, ramWEN, dwait} !== 3'b001) begin
            n_errors++;
            $display("FAIL abandon_drop: got ramREN,ramWEN,dwait=%b expected 001", {ramREN, ramWEN, dwait});
        end
        tick();
        iREN = 1'b1; iaddr = 32'h20;
        #1;
        n_checks++;
        if ({ramREN, iwait, dwait} !== 3'b011 || ramaddr !== 32'h0) begin
            n_errors++;
            $display("FAIL abandon_idle: got ramREN,iwait,dwait=%b addr=%h expected 011 0",
                     {ramREN, iwait, dwait}, ramaddr);
        end
        tick();
        ramstate = RS_ACCESS;
        #1;
        n_checks++;
        if ({ramREN, iwait} !== 2'b10 || ramaddr !== 32'h20) begin
            n_errors++;
            $display("FAIL abandon_next: got ramREN,iwait=%b addr=%h expected 10 20", {ramREN, iwait}, ramaddr);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_grant();
        dWEN = 1'b1; iREN = 1'b1; daddr = 32'h500; dstore = 32'h0000_A5A5; iaddr = 32'h600;
        tick();
        ramstate = RS_ACCESS;
        #1;
        n_checks++;
        if (dwait !== 1'b0) begin
            n_errors++;
            $display("FAIL rstmid_first: got dwait=%b expected 0", dwait);
        end
        tick();
        ramstate = RS_FREE;
        tick();
        ramstate = RS_BUSY;
        #1;
        n_checks++;
        if ({ramWEN, dwait} !== 2'b11 || dut.starve_cnt !== 3'd1) begin
            n_errors++;
            $display("FAIL rstmid_pre: got ramWEN,dwait=%b starve=%0d expected 11 1",
                     {ramWEN, dwait}, dut.starve_cnt);
        end
        RST = 1'b1;
        #1;
        n_checks++;
        if ({ramWEN, ramREN, dwait, iwait} !== 4'b0011 || ramstore !== 32'd0 || dut.starve_cnt !== 3'd0) begin
            n_errors++;
            $display("FAIL rstmid_async: got strobes=%b store=%h starve=%0d expected 0011 0 0",
                     {ramWEN, ramREN, dwait, iwait}, ramstore, dut.starve_cnt);
        end
        tick();
        RST = 1'b0;
        #1;
        n_checks++;
        if ({ramWEN, dwait} !== 2'b01) begin
            n_errors++;
            $display("FAIL rstmid_release: got ramWEN,dwait=%b expected 01", {ramWEN, dwait});
        end
        tick();
        ramstate = RS_ACCESS;
        #1;
        n_checks++;
        if ({ramWEN, dwait, iwait} !== 3'b101 || ramaddr !== 32'h500) begin
            n_errors++;
            $display("FAIL rstmid_regrant: got ramWEN,dwait,iwait=%b addr=%h expected 101 500",
                     {ramWEN, dwait, iwait}, ramaddr);
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_instr_fetch();
        test_write_priority();
        test_starvation();
        test_busy_wait();
        test_error_retry();
        test_abandon();
        test_reset_mid_grant();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mem_arbiter
